// File: rtl/keypad_event_pkg.sv
// Shared types for the keypad event block: key count, queued event record, wait FSM states.
// No logic of its own; the lowest_key helper is pure combinational priority.
// Used by keypad_event and its testbench.
package keypad_pkg;

  localparam int KEY_COUNT = 16;

  typedef struct packed {
    logic       press;
    logic [3:0] key;
  } key_evt_t;

  typedef enum logic [1:0] {IDLE, ARMED, HELD, DONE} wait_state_t;

  // Index of the lowest set bit; 0 when none is set (callers gate with |v).
  function automatic logic [3:0] lowest_key(input logic [KEY_COUNT-1:0] v);
    logic [3:0] k;
    k = 4'd0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (v[i]) k = 4'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_event_debounce.sv
// One key's debouncer: stable level flips after DEBOUNCE_CYCLES mismatched samples.
// Latency: flip on edge DEBOUNCE_CYCLES-1 of a held change; rise/fall pulses are
// combinational and valid in the cycle before the flip edge. No backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = i_raw ^ r_stable;
  assign w_flip = w_diff && (r_cnt == LAST);

  // Count consecutive mismatches; flip the stable level when the run is long enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_flip) begin
      r_cnt    <= '0;
      r_stable <= ~r_stable;
    end else if (w_diff) begin
      r_cnt    <= r_cnt + CW'(1);
    end else begin
      r_cnt    <= '0;
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_flip && !r_stable;
  assign o_fall   = w_flip &&  r_stable;

endmodule

// File: rtl/keypad_event.sv
// Keypad consumer: debounce 16 keys, queue press/release events, service FX0A wait.
// Latency: flip at T, enqueue at T+1 (evt_valid after T+1), wait_done in the cycle after T+1.
// Backpressure: evt_ready low holds the head and fills the queue; further edges coalesce in
// per-key pending bits and a lost edge sets sticky overflow.
// Build option KEYPAD_EVT_WAIT_RELEASE_EN: FX0A completes on release of the captured key.
module keypad_event
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_COUNT-1:0] keys_raw,
  output logic [KEY_COUNT-1:0] keys_stable,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [3:0]           evt_key,
  output logic                 evt_press,
  input  logic                 wait_req,
  output logic                 wait_done,
  output logic [3:0]           wait_key,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [KEY_COUNT-1:0] w_stable, w_rise, w_fall;

  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (keys_raw[k]),
      .o_stable(w_stable[k]),
      .o_rise  (w_rise[k]),
      .o_fall  (w_fall[k])
    );
  end

  assign keys_stable = w_stable;

  logic [KEY_COUNT-1:0] r_pend_press, r_pend_rel;
  logic [KEY_COUNT-1:0] w_pend_any, w_clr_press, w_clr_rel;
  logic [3:0]           w_sel_key;
  logic                 w_sel_press, w_push, w_pop, w_full, w_head_is_wr;
  key_evt_t             w_push_dat, w_head_nxt, r_head;
  key_evt_t             r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd, w_rd_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_evt_vld, r_overflow;

  assign w_full = (r_cnt == FULL_CNT);

  // Drain selection and FIFO next-state; a pending pair is emitted in the order it happened.
  always_comb begin
    w_pend_any = r_pend_press | r_pend_rel;
    w_sel_key  = lowest_key(w_pend_any);
    if (r_pend_press[w_sel_key] && r_pend_rel[w_sel_key]) begin
      w_sel_press = !w_stable[w_sel_key];
    end else begin
      w_sel_press = r_pend_press[w_sel_key];
    end
    w_pop            = r_evt_vld && evt_ready;
    w_push           = (|w_pend_any) && (!w_full || w_pop);
    w_push_dat.press = w_sel_press;
    w_push_dat.key   = w_sel_key;
    w_clr_press      = '0;
    w_clr_rel        = '0;
    if (w_push) begin
      if (w_sel_press) w_clr_press[w_sel_key] = 1'b1;
      else             w_clr_rel[w_sel_key]   = 1'b1;
    end
    w_rd_nxt  = w_pop ? r_rd + AW'(1) : r_rd;
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + CW'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - CW'(1);
    // The new entry becomes the head when nothing older survives this cycle.
    w_head_is_wr = (r_cnt == '0) || ((r_cnt == CW'(1)) && w_pop);
    if (w_cnt_nxt == '0)             w_head_nxt = '0;
    else if (w_push && w_head_is_wr) w_head_nxt = w_push_dat;
    else                             w_head_nxt = r_mem[w_rd_nxt];
  end

  // Pending edge bits and sticky overflow when an edge lands on an unconsumed one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_press <= '0;
      r_pend_rel   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_pend_press <= (r_pend_press & ~w_clr_press) | w_rise;
      r_pend_rel   <= (r_pend_rel   & ~w_clr_rel)   | w_fall;
      if (|((w_rise & r_pend_press & ~w_clr_press) | (w_fall & r_pend_rel & ~w_clr_rel))) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Event storage; contents need no reset because the head register masks them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_dat;
  end

  // FIFO pointers, occupancy and registered head outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_evt_vld <= 1'b0;
      r_head    <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd      <= w_rd_nxt;
      r_cnt     <= w_cnt_nxt;
      r_evt_vld <= (w_cnt_nxt != '0);
      r_head    <= w_head_nxt;
    end
  end

  assign evt_valid = r_evt_vld;
  assign evt_key   = r_head.key;
  assign evt_press = r_head.press;
  assign overflow  = r_overflow;

  wait_state_t          r_wst;
  logic                 r_wait_req_q, r_wait_done;
  logic [KEY_COUNT-1:0] r_rise_q;
  logic [3:0]           r_wait_key;
`ifdef KEYPAD_EVT_WAIT_RELEASE_EN
  logic [KEY_COUNT-1:0] r_fall_q;
  logic [3:0]           r_wait_cap;
`endif

  // FX0A wait FSM on one-cycle-delayed stable edges; only edges seen while armed count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wst        <= IDLE;
      r_wait_req_q <= 1'b0;
      r_rise_q     <= '0;
      r_wait_done  <= 1'b0;
      r_wait_key   <= 4'd0;
`ifdef KEYPAD_EVT_WAIT_RELEASE_EN
      r_fall_q     <= '0;
      r_wait_cap   <= 4'd0;
`endif
    end else begin
      r_wait_req_q <= wait_req;
      r_rise_q     <= w_rise;
      r_wait_done  <= 1'b0;
`ifdef KEYPAD_EVT_WAIT_RELEASE_EN
      r_fall_q     <= w_fall;
`endif
      case (r_wst)
        IDLE: if (wait_req && !r_wait_req_q) r_wst <= ARMED;
        ARMED: begin
          if (!wait_req) begin
            r_wst <= IDLE;
          end else if (|r_rise_q) begin
`ifdef KEYPAD_EVT_WAIT_RELEASE_EN
            r_wait_cap  <= lowest_key(r_rise_q);
            r_wst       <= HELD;
`else
            r_wait_key  <= lowest_key(r_rise_q);
            r_wait_done <= 1'b1;
            r_wst       <= DONE;
`endif
          end
        end
`ifdef KEYPAD_EVT_WAIT_RELEASE_EN
        HELD: begin
          if (!wait_req) begin
            r_wst <= IDLE;
          end else if (r_fall_q[r_wait_cap]) begin
            r_wait_key  <= r_wait_cap;
            r_wait_done <= 1'b1;
            r_wst       <= DONE;
          end
        end
`endif
        DONE:    r_wst <= IDLE;
        default: r_wst <= IDLE;
      endcase
    end
  end

  assign wait_done = r_wait_done;
  assign wait_key  = r_wait_key;

endmodule
